// File: rtl/cpu_cache_pkg.sv
// Shared types for the CPU data cache: access mode, bus/CPU request and response
// structs, FSM states and line merge/extract helpers.
package cpu_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int WORD_WIDTH = 32;
    localparam int LINE_WIDTH = 128;
    localparam int OFFSET_W   = 4;

    typedef enum logic {BYTE = 1'b0, WORD = 1'b1} mode_t;

    typedef enum logic [1:0] {IDLE, WAIT_BUS, REFILL_REQ, WAIT_FILL} cache_state_t;

    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        mode_t                 mode;
        logic [WORD_WIDTH-1:0] data;
    } cache_req_t;

    typedef struct packed {
        logic                  hit;
        logic [WORD_WIDTH-1:0] data;
    } cache_rsp_t;

    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] data;
    } mem_req_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] data;
    } mem_rsp_t;

    // WORD accesses ignore off[1:0]; BYTE accesses use the low byte of data.
    function automatic logic [LINE_WIDTH-1:0] line_merge(
        input logic [LINE_WIDTH-1:0] line,
        input logic [OFFSET_W-1:0]   off,
        input mode_t                 mode,
        input logic [WORD_WIDTH-1:0] data
    );
        logic [LINE_WIDTH-1:0] r;
        r = line;
        if (mode == WORD) r[{off[3:2], 5'd0} +: WORD_WIDTH] = data;
        else              r[{off, 3'd0} +: 8] = data[7:0];
        return r;
    endfunction

    function automatic logic [WORD_WIDTH-1:0] line_extract(
        input logic [LINE_WIDTH-1:0] line,
        input logic [OFFSET_W-1:0]   off,
        input mode_t                 mode
    );
        logic [WORD_WIDTH-1:0] r;
        if (mode == WORD) r = line[{off[3:2], 5'd0} +: WORD_WIDTH];
        else              r = {{(WORD_WIDTH-8){1'b0}}, line[{off, 3'd0} +: 8]};
        return r;
    endfunction
endpackage

// File: rtl/cpu_cache_array.sv
// Tag/valid/dirty/data storage: combinational lookup at idx_i, byte/word write
// port and whole-line fill port sharing the same index.
module cpu_cache_array
    import cpu_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = ADDR_WIDTH - OFFSET_W - IDX_W
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [TAG_W-1:0]      tag_i,
    output logic                  hit_o,
    output logic                  valid_o,
    output logic                  dirty_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic [LINE_WIDTH-1:0] line_o,
    input  logic                  wr_en_i,
    input  logic [OFFSET_W-1:0]   wr_off_i,
    input  mode_t                 wr_mode_i,
    input  logic [WORD_WIDTH-1:0] wr_data_i,
    input  logic                  fill_en_i,
    input  logic [TAG_W-1:0]      fill_tag_i,
    input  logic [LINE_WIDTH-1:0] fill_data_i
);
    logic [NUM_LINES-1:0]                 valid_a;
    logic [NUM_LINES-1:0]                 dirty_a;
    logic [NUM_LINES-1:0][TAG_W-1:0]      tag_a;
    logic [NUM_LINES-1:0][LINE_WIDTH-1:0] data_a;

    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
        localparam logic [IDX_W-1:0] LINE_IDX = IDX_W'(gi);
        logic                  sel;
        logic                  valid_q;
        logic                  dirty_q;
        logic [TAG_W-1:0]      tag_q;
        logic [LINE_WIDTH-1:0] data_q;

        assign sel = (idx_i == LINE_IDX);

        always_ff @(posedge clock_i or negedge reset_ni) begin
            if (!reset_ni) begin
                valid_q <= 1'b0;
                dirty_q <= 1'b0;
            end else if (sel && fill_en_i) begin
                valid_q <= 1'b1;
                dirty_q <= 1'b0;
            end else if (sel && wr_en_i) begin
                dirty_q <= 1'b1;
            end
        end

        // Tag and data carry no reset; valid gates every use of them.
        always_ff @(posedge clock_i) begin
            if (sel && fill_en_i) begin
                tag_q  <= fill_tag_i;
                data_q <= fill_data_i;
            end else if (sel && wr_en_i) begin
                data_q <= line_merge(data_q, wr_off_i, wr_mode_i, wr_data_i);
            end
        end

        assign valid_a[gi] = valid_q;
        assign dirty_a[gi] = dirty_q;
        assign tag_a[gi]   = tag_q;
        assign data_a[gi]  = data_q;
    end

    assign valid_o = valid_a[idx_i];
    assign dirty_o = dirty_a[idx_i];
    assign tag_o   = tag_a[idx_i];
    assign line_o  = data_a[idx_i];
    assign hit_o   = valid_o && (tag_o == tag_i);
endmodule

// File: rtl/cpu_cache.sv
// Direct-mapped write-back, write-allocate data cache: same-cycle hits, and a
// miss FSM that writes back a dirty victim and refills over the shared bus.
module cpu_cache
    import cpu_pkg::*;
#(
    parameter int NUM_LINES = 4
) (
    input  logic       clock_i,
    input  logic       reset_ni,
    input  cache_req_t cache_request_i,
    output cache_rsp_t cache_response_o,
    input  logic       mem_bus_available_i,
    output mem_req_t   mem_bus_request_o,
    input  mem_rsp_t   mem_bus_response_i
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - OFFSET_W - IDX_W;

    cache_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pend_q, pend_d;
    mem_req_t              bus_q, bus_d;

    logic                  access, is_write, lookup_hit, hit, wr_en, fill_en;
    logic [IDX_W-1:0]      req_idx, pend_idx, arr_idx;
    logic [TAG_W-1:0]      req_tag, pend_tag, vic_tag;
    logic                  vic_valid, vic_dirty;
    logic [LINE_WIDTH-1:0] arr_line;

    assign access   = cache_request_i.read || cache_request_i.write;
    assign is_write = cache_request_i.write;
    assign req_idx  = cache_request_i.addr[OFFSET_W +: IDX_W];
    assign req_tag  = cache_request_i.addr[ADDR_WIDTH-1 -: TAG_W];
    assign pend_idx = pend_q[OFFSET_W +: IDX_W];
    assign pend_tag = pend_q[ADDR_WIDTH-1 -: TAG_W];

    // Outside IDLE the array is steered to the pending line for victim/fill.
    assign arr_idx = (state_q == IDLE) ? req_idx : pend_idx;
    assign hit     = (state_q == IDLE) && access && lookup_hit;
    assign wr_en   = hit && is_write;

    cpu_cache_array #(
        .NUM_LINES(NUM_LINES),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_array (
        .clock_i    (clock_i),
        .reset_ni   (reset_ni),
        .idx_i      (arr_idx),
        .tag_i      (req_tag),
        .hit_o      (lookup_hit),
        .valid_o    (vic_valid),
        .dirty_o    (vic_dirty),
        .tag_o      (vic_tag),
        .line_o     (arr_line),
        .wr_en_i    (wr_en),
        .wr_off_i   (cache_request_i.addr[OFFSET_W-1:0]),
        .wr_mode_i  (cache_request_i.mode),
        .wr_data_i  (cache_request_i.data),
        .fill_en_i  (fill_en),
        .fill_tag_i (pend_tag),
        .fill_data_i(mem_bus_response_i.data)
    );

    always_comb begin
        cache_response_o     = '0;
        cache_response_o.hit = hit;
        if (hit && !is_write)
            cache_response_o.data = line_extract(arr_line, cache_request_i.addr[OFFSET_W-1:0],
                                                 cache_request_i.mode);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            pend_q  <= '0;
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            bus_q   <= bus_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        bus_d         = bus_q;
        bus_d.read    = 1'b0;
        bus_d.write   = 1'b0;
        fill_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access && !lookup_hit) begin
                    state_d = WAIT_BUS;
                    pend_d  = {cache_request_i.addr[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'(0)};
                end
            end
            WAIT_BUS: begin
                if (mem_bus_available_i) begin
                    if (vic_valid && vic_dirty) begin
                        bus_d.write = 1'b1;
                        bus_d.addr  = {vic_tag, pend_idx, OFFSET_W'(0)};
                        bus_d.data  = arr_line;
                        state_d     = REFILL_REQ;
                    end else begin
                        bus_d.read = 1'b1;
                        bus_d.addr = pend_q;
                        state_d    = WAIT_FILL;
                    end
                end
            end
            REFILL_REQ: begin
                if (mem_bus_available_i) begin
                    bus_d.read = 1'b1;
                    bus_d.addr = pend_q;
                    state_d    = WAIT_FILL;
                end
            end
            WAIT_FILL: begin
                if (mem_bus_response_i.valid && (mem_bus_response_i.addr == pend_q)) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_bus_request_o = bus_q;
endmodule

// File: tb/tb_cpu_cache.sv
// Directed bench for cpu_cache: reset, clean miss/refill, hits, byte/word
// access, dirty eviction and reset during a miss.
module tb_cpu_cache;
    import cpu_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    cache_req_t req;
    cache_rsp_t rsp;
    logic       avail;
    mem_req_t   breq;
    mem_rsp_t   bresp;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cpu_cache #(.NUM_LINES(4)) dut (
        .clock_i            (clock),
        .reset_ni           (reset_n),
        .cache_request_i    (req),
        .cache_response_o   (rsp),
        .mem_bus_available_i(avail),
        .mem_bus_request_o  (breq),
        .mem_bus_response_i (bresp)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input mode_t mode, input logic [31:0] data);
        req.read  = rd;
        req.write = wr;
        req.addr  = addr;
        req.mode  = mode;
        req.data  = data;
        #1;
    endtask

    logic [31:0] exp_w [4];

    initial begin
        exp_w[0] = 32'hAAAAAAAA;
        exp_w[1] = 32'hBBBBBBBB;
        exp_w[2] = 32'hCCCCCCCC;
        exp_w[3] = 32'hDDDDDDDD;
        reset_n = 1'b0;
        req     = '0;
        avail   = 1'b0;
        bresp   = '0;
        cyc();
        chk("rst_hit",   rsp.hit,    0);
        chk("rst_rdata", rsp.data,   0);
        chk("rst_bus_rd", breq.read,  0);
        chk("rst_bus_wr", breq.write, 0);
        chk("rst_bus_addr", breq.addr, 0);
        chk("rst_bus_data", breq.data, 0);
        reset_n = 1'b1;

        // Clean miss with the bus held off for two cycles
        set_req(1, 0, 32'h0, WORD, 0);
        chk("miss0_hit", rsp.hit, 0);
        cyc();
        chk("unavail_rd1", breq.read, 0);
        cyc();
        chk("unavail_rd2", breq.read, 0);
        chk("waitbus_hit", rsp.hit, 0);
        avail = 1'b1;
        cyc();
        chk("rd_pulse", breq.read, 1);
        chk("rd_addr", breq.addr, 32'h0);
        avail = 1'b0;
        cyc();
        chk("rd_pulse_end", breq.read, 0);

        set_req(0, 1, 32'h0, WORD, 32'h11223344);
        bresp.valid = 1'b1;
        bresp.addr  = 32'h40;
        bresp.data  = 128'h12345678_12345678_12345678_12345678;
        cyc();
        chk("mismatch_ignored", rsp.hit, 0);
        bresp.addr = 32'h0;
        bresp.data = 128'hFFEEDDCC_FFEEDDCC_FFEEDDCC_FFEEDDCC;
        cyc();
        bresp.valid = 1'b0;
        #1;
        chk("wr_hit_after_fill", rsp.hit, 1);
        cyc();
        set_req(1, 0, 32'h0, WORD, 0);
        chk("rd_hit0", rsp.hit, 1);
        chk("rd_w0", rsp.data, 32'h11223344);
        set_req(1, 0, 32'h1, BYTE, 0);
        chk("rd_b1", rsp.data, 32'h00000033);
        set_req(1, 0, 32'h3, BYTE, 0);
        chk("rd_b3", rsp.data, 32'h00000011);
        set_req(1, 0, 32'h4, WORD, 0);
        chk("rd_w1", rsp.data, 32'hFFEEDDCC);
        cyc();

        // Dirty victim at index 0 evicted by 0x40
        set_req(1, 0, 32'h40, WORD, 0);
        chk("miss40_hit", rsp.hit, 0);
        cyc();
        avail = 1'b1;
        cyc();
        chk("wb_pulse", breq.write, 1);
        chk("wb_no_rd", breq.read, 0);
        chk("wb_addr", breq.addr, 32'h0);
        chk("wb_data", breq.data, 128'hFFEEDDCC_FFEEDDCC_FFEEDDCC_11223344);
        cyc();
        chk("wb_end", breq.write, 0);
        chk("refill_rd", breq.read, 1);
        chk("refill_addr", breq.addr, 32'h40);
        avail = 1'b0;
        cyc();
        chk("refill_rd_end", breq.read, 0);
        bresp.valid = 1'b1;
        bresp.addr  = 32'h40;
        bresp.data  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        cyc();
        bresp.valid = 1'b0;
        #1;
        chk("hit40", rsp.hit, 1);
        chk("rd40", rsp.data, 32'h03020100);
        set_req(1, 0, 32'h45, BYTE, 0);
        chk("rd_b45", rsp.data, 32'h00000005);
        set_req(0, 1, 32'h46, BYTE, 32'hA5A5A55A);
        chk("wr_b46_hit", rsp.hit, 1);
        cyc();
        set_req(1, 0, 32'h44, WORD, 0);
        chk("rd_w44", rsp.data, 32'h075A0504);
        cyc();

        // Evict 0x40 back out and refill 0x0; avail high from the start
        set_req(1, 0, 32'h0, WORD, 0);
        chk("miss0b_hit", rsp.hit, 0);
        avail = 1'b1;
        cyc();
        chk("idle_no_pulse", breq.write, 0);
        cyc();
        chk("wb2_pulse", breq.write, 1);
        chk("wb2_addr", breq.addr, 32'h40);
        chk("wb2_data", breq.data, 128'h0F0E0D0C_0B0A0908_075A0504_03020100);
        cyc();
        chk("refill2_rd", breq.read, 1);
        chk("refill2_addr", breq.addr, 32'h0);
        avail       = 1'b0;
        bresp.valid = 1'b1;
        bresp.addr  = 32'h0;
        bresp.data  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        cyc();
        bresp.valid = 1'b0;
        #1;
        chk("refill2_rd_end", breq.read, 0);
        for (int i = 0; i < 4; i++) begin
            set_req(1, 0, 32'(i * 4), WORD, 0);
            chk($sformatf("seq_hit%0d", i), rsp.hit, 1);
            chk($sformatf("seq_data%0d", i), rsp.data, exp_w[i]);
            chk($sformatf("seq_bus%0d", i), {breq.read, breq.write}, 2'b00);
            cyc();
        end
        set_req(1, 0, 32'h5, BYTE, 0);
        chk("rd_b5", rsp.data, 32'h000000BB);
        set_req(0, 1, 32'h3, WORD, 32'hCAFEF00D);
        cyc();
        set_req(1, 0, 32'h0, WORD, 0);
        chk("wr_word_unaligned", rsp.data, 32'hCAFEF00D);
        set_req(1, 0, 32'h4, WORD, 0);
        chk("neighbour_intact", rsp.data, 32'hBBBBBBBB);
        cyc();

        // Reset asserted while a write-back pulse is on the bus
        set_req(1, 0, 32'h80, WORD, 0);
        cyc();
        avail = 1'b1;
        cyc();
        chk("wb3_pulse", breq.write, 1);
        chk("wb3_data", breq.data, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_CAFEF00D);
        reset_n = 1'b0;
        #1;
        chk("midrst_wr", breq.write, 0);
        chk("midrst_addr", breq.addr, 0);
        chk("midrst_data", breq.data, 0);
        cyc();
        reset_n = 1'b1;
        avail   = 1'b0;
        set_req(1, 0, 32'h0, WORD, 0);
        chk("post_rst_invalid", rsp.hit, 0);
        chk("post_rst_rdata", rsp.data, 0);
        cyc();
        chk("post_rst_no_rd", breq.read, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_cache.md
# cpu_cache

Direct-mapped, write-back, write-allocate data cache between the CPU load/store stage and the shared memory bus. It serves byte and word accesses from 128-bit lines, answering hits in the same cycle. On a miss it arbitrates for the bus via `mem_bus_available`, writes back a dirty victim and refills the line.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- WORD_WIDTH, 32, CPU data width
- LINE_WIDTH, 128, line and bus data width (16 bytes, 4 words)
- NUM_LINES, 4, number of lines (power of two); index = addr[4 +: log2(NUM_LINES)], tag = upper bits

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- cache_request.read  in  1  load request
- cache_request.write  in  1  store request
- cache_request.addr  in  ADDR_WIDTH  byte address
- cache_request.mode  in  mode_t  BYTE or WORD
- cache_request.data  in  WORD_WIDTH  store data (byte in [7:0])
- cache_response.hit  out  1  access completes this cycle
- cache_response.data  out  WORD_WIDTH  load data (byte zero-extended)
- mem_bus_available  in  1  bus granted to this cache this cycle
- mem_bus_request.read  out  1  line read, one-cycle pulse
- mem_bus_request.write  out  1  line write-back, one-cycle pulse
- mem_bus_request.addr  out  ADDR_WIDTH  line-aligned address (addr[3:0]=0)
- mem_bus_request.data  out  LINE_WIDTH  victim line for write-back
- mem_bus_response.valid  in  1  refill data present
- mem_bus_response.addr  in  ADDR_WIDTH  line address of the refill
- mem_bus_response.data  in  LINE_WIDTH  refill line, word 0 in [31:0]

## Operation
- Per line: valid, dirty, tag, 128-bit data. Reset clears all valid and dirty bits. Data is not reset.
- Hit = state IDLE & (read|write) & valid[idx] & tag match. It is combinational.
- Read hit: response.data = selected word (addr[3:2]), or the selected byte (addr[3:0]) zero-extended.
- Write hit: the selected word or byte is updated at the clock edge and dirty is set. WORD writes ignore addr[1:0].
- read and write both set: treated as write.
- FSM:
  - IDLE: on (read|write) miss, go to WAIT_BUS.
  - WAIT_BUS: when mem_bus_available=1:
    - victim valid & dirty: issue write pulse with the victim address and data, go to REFILL_REQ.
    - otherwise: issue read pulse, go to WAIT_FILL.
  - REFILL_REQ: when mem_bus_available=1, issue read pulse, go to WAIT_FILL.
  - WAIT_FILL: when response.valid=1 and response.addr equals the pending line address:
    - write the line, set valid, clear dirty, set tag.
    - go to IDLE.
    - the request then re-evaluates as a hit.
  - A response with a mismatched address is ignored.
- The pending miss address is latched on leaving IDLE. A request change during a miss does not affect the refill address.

## Timing
- Reset values: hit=0, response.data=0, bus read=0, write=0, addr=0, data=0, state IDLE.
- Bus request outputs are registered. The pulse appears the cycle after the edge that samples mem_bus_available=1, lasts exactly one cycle, and then deasserts.
- Miss with bus unavailable: no bus activity for as long as available=0.
- Clean miss latency:
  - edge 1: IDLE→WAIT_BUS.
  - next edge with available=1: read pulse.
  - fill at the edge sampling valid.
  - hit=1 combinationally in the following cycle.
- Reset asserted mid-miss: abort immediately to IDLE, all lines invalid, outputs zero.

## Structure
- Shared package `cpu_pkg`:
  - `mode_t` enum {BYTE, WORD}
  - ADDR_WIDTH, WORD_WIDTH, LINE_WIDTH constants
- The two request/response interfaces are declared alongside it.
- One sub-module `cpu_cache_array` holds the tag/valid/dirty/data storage. It provides combinational lookup, a byte/word write port and a line fill port.
- The FSM and bus logic live in `cpu_cache`.

## Test plan
- Reset: hold reset=0 for 1 cycle → hit=0, bus read=0, write=0.
- Read WORD 0x0, available=0 for 1 cycle → no bus read. Then available=1 → read=1, addr=0x0 for exactly one cycle, then 0.
- Fill response valid, addr 0x0, data 0xFFEEDDCCFFEEDDCCFFEEDDCCFFEEDDCC, with a write of 0x11223344 pending to 0x0 → next cycle hit=1. After the edge, a read at 0x0 returns 0x11223344.
- Fill 0xDDDDDDDDCCCCCCCCBBBBBBBBAAAAAAAA at 0x0, then read 0x0/0x4/0x8/0xC → hit=1 each cycle, data AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD, no bus traffic.
- BYTE read at 0x5 on that line → 0x000000BB.
- Dirty line 0x0, then read 0x40 (same index, NUM_LINES=4) → write pulse, addr 0x0, victim data. Next granted cycle: read pulse, addr 0x40.
